// File: rtl/ring_timing_pkg.sv
// Shared definitions for consumers of the 6-bit one-hot ring counter.
//   T0..T5      : one-hot phase constants (T0 is the MSB, T5 the LSB)
//   state_t     : controller states for phase-driven sequencers
//   step_phase  : phase value a step index is expected to coincide with
package ring_timing_pkg;

    localparam logic [5:0] T0 = 6'b100000;
    localparam logic [5:0] T1 = 6'b010000;
    localparam logic [5:0] T2 = 6'b001000;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b000010;
    localparam logic [5:0] T5 = 6'b000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic logic [5:0] step_phase(input logic [2:0] step);
        logic [5:0] ph;
        case (step)
            3'd1:    ph = T1;
            3'd2:    ph = T2;
            3'd3:    ph = T3;
            3'd4:    ph = T4;
            3'd5:    ph = T5;
            default: ph = T0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/onehot6_check.sv
// Combinational one-hot detector for a 6-bit phase bus.
//   in     : phase bus to examine
//   onehot : 1 when exactly one bit of in is set
module onehot6_check (
    input  logic [5:0] in,
    output logic       onehot
);

    // Non-zero and clearing the lowest set bit leaves nothing behind.
    assign onehot = (in != 6'd0) && ((in & (in - 6'd1)) == 6'd0);

endmodule

// File: rtl/serial_mult_seq.sv
// Phase-driven 4x4 shift-and-add multiplier.
// A start request is aligned to the next T0, one add-shift step runs in each
// of T1..T4, and the product is registered at T5 with a one-cycle done pulse.
// The timing bus is monitored; a non-one-hot or out-of-sequence phase sets a
// sticky phase_err and aborts the operation.
//   clk       : system clock
//   reset     : synchronous active-low reset
//   timing    : one-hot phase bus, timing[5]=T0 .. timing[0]=T5
//   start     : single-cycle request, honoured only when idle
//   a, b      : multiplicand / multiplier, sampled with the accepted start
//   busy      : high from the accepted start through the T5 step
//   done      : one-cycle pulse when product becomes valid
//   product   : a*b, held until the next completion
//   phase_err : sticky timing-fault flag, cleared only by reset
module serial_mult_seq
    import ring_timing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] timing,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic       phase_err
);

    state_t     state,     state_n;
    logic [7:0] m,         m_n;
    logic [3:0] q,         q_n;
    logic [7:0] acc,       acc_n;
    logic [2:0] step,      step_n;
    logic       busy_r,    busy_n;
    logic       done_r,    done_n;
    logic [7:0] product_r, product_n;
    logic       err_r,     err_n;
    logic       accept;
    logic       timing_ok;

    onehot6_check u_onehot (
        .in     (timing),
        .onehot (timing_ok)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            m         <= '0;
            q         <= '0;
            acc       <= '0;
            step      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_n;
            m         <= m_n;
            q         <= q_n;
            acc       <= acc_n;
            step      <= step_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            product_r <= product_n;
            err_r     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        m_n       = m;
        q_n       = q;
        acc_n     = acc;
        step_n    = step;
        busy_n    = busy_r;
        done_n    = 1'b0;
        product_n = product_r;
        err_n     = err_r;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                // A malformed phase in the start cycle wins over the request,
                // so an operation never begins on a bus already known bad.
                if (!timing_ok) begin
                    err_n = 1'b1;
                end else if (start && !err_r) begin
                    accept = 1'b1;
                    m_n    = {4'd0, a};
                    q_n    = b;
                    acc_n  = '0;
                    busy_n = 1'b1;
                    if (timing == T0) begin
                        state_n = RUN;
                        step_n  = 3'd1;
                    end else begin
                        state_n = ARMED;
                    end
                end
            end

            ARMED: begin
                if (!timing_ok) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (timing == T0) begin
                    state_n = RUN;
                    step_n  = 3'd1;
                end
            end

            RUN: begin
                if (!timing_ok || (timing != step_phase(step))) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (step == 3'd5) begin
                    product_n = acc;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    if (q[0]) begin
                        acc_n = acc + m;
                    end
                    m_n    = m << 1;
                    q_n    = q >> 1;
                    step_n = step + 3'd1;
                end
            end

            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // busy covers the accepting cycle itself, then the registered flag.
    assign busy      = busy_r | accept;
    assign done      = done_r;
    assign product   = product_r;
    assign phase_err = err_r;

endmodule

// File: doc/serial_mult_seq.md
# serial_mult_seq

Phase-driven 4x4 shift-and-add multiplier controlled by the six one-hot timing phases from the upstream 6-bit ring counter. It accepts a start request with two 4-bit operands, aligns to the next T0, and performs one add-shift step per phase T1..T4. At T5 it registers the 8-bit product and pulses `done`. It also monitors the timing bus and flags any phase that is not one-hot or out of sequence.

## Interface
Parameters: none; all widths are fixed.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `timing`  in  6  one-hot phase bus from the ring counter. `timing[5]`=T0, `timing[4]`=T1 … `timing[0]`=T5. The active bit moves one position right per clock and wraps from T5 to T0.
- `start`  in  1  single-cycle request; honoured only when idle.
- `a`  in  4  multiplicand, sampled in the accepted start cycle.
- `b`  in  4  multiplier, sampled in the accepted start cycle.
- `busy`  out  1  high from the accepted start through the T5 step.
- `done`  out  1  one-cycle pulse when `product` becomes valid.
- `product`  out  8  a*b; holds its value until the next completion.
- `phase_err`  out  1  sticky timing-fault flag; cleared only by reset.

## Operation
- States: IDLE, ARMED, RUN. Internal registers:
  - M: 8 bits, multiplicand shifted left.
  - Q: 4 bits, multiplier shifted right.
  - ACC: 8 bits, accumulator.
  - step: 3 bits.
- IDLE:
  - On `start` with `phase_err`=0, capture a→M, b→Q, clear ACC, set `busy`.
  - If `timing`==T0 in that same cycle, go directly to RUN with step=1. Otherwise go to ARMED.
- ARMED: wait for `timing`==T0, then go to RUN with step=1.
- RUN, on each cycle where `timing` equals the phase for step k (k=1..4, T1..T4):
  - if Q[0]=1, ACC ← ACC+M;
  - then M ← M<<1, Q ← Q>>1, step ← k+1.
- RUN at T5:
  - `product` ← ACC, `done` ← 1 for one cycle, `busy` ← 0, go to IDLE.
- Arithmetic: ACC is 8 bits and cannot overflow (maximum 15*15=225). M is 8 bits and its top bit is never shifted out in 4 steps.
- `start` while `busy`=1 is ignored; there is no queueing.
- Phase fault: in ARMED or RUN, a `timing` value that is not exactly one-hot sets `phase_err`. In RUN, a one-hot phase other than the expected one also sets `phase_err`.
  - On a fault the block aborts to IDLE, clears `busy`, raises no `done`, and leaves `product` unchanged.
  - While `phase_err`=1, `start` is ignored.
- A non-one-hot `timing` in IDLE also sets `phase_err`.

## Timing
- Reset values (applied when `reset`=0 at a clock edge): state=IDLE, `busy`=0, `done`=0, `product`=8'h00, `phase_err`=0, M/Q/ACC=0.
- A reset asserted mid-operation aborts immediately with no `done`.
- The upstream ring advances every clock, so RUN spans exactly the cycles at T1..T5.
- Latency from accepted `start` to `done`:
  - 6 cycles if `start` coincides with T0;
  - otherwise (wait until the next T0) + 6 cycles.
  - Worst case is `start` at T1: 5 + 6 = 11 cycles.
- `done` is high in the cycle after the T5 edge, which is the next T0 cycle. A `start` in that cycle is accepted as a T0 start, so back-to-back operations complete every 6 cycles.
- `product` updates on the same edge that raises `done`.
- `phase_err` is registered: it goes high one cycle after the faulty `timing` value is sampled.

## Structure
- Shared package `ring_timing_pkg` holds:
  - phase constants T0..T5 as 6-bit one-hot localparams (T0=6'b100000);
  - the state encoding IDLE/ARMED/RUN;
  - a function that returns the expected phase for a given step.
- One sub-module, `onehot6_check`: combinational, outputs 1 when exactly one of its 6 input bits is set. It is reusable by any other consumer of the ring counter.
- The rest is a single FSM plus the datapath registers in `serial_mult_seq`.

## Test plan
- Drive `timing` from a live ring counter. Apply `start` at T0 with a=13, b=11: `done` arrives 6 cycles later with `product`=8'h8F, and `busy` is high for exactly 6 cycles.
- Apply `start` at T3 with a=15, b=15: `busy` rises at once, the ARMED wait lasts 3 cycles, and `done` arrives 9 cycles after `start` with `product`=8'hE1.
- Apply a=0, b=9, then a=7, b=0: both give `product`=0 with a normal `done` pulse. Then issue back-to-back starts in the `done` cycles with a=3, b=5 and a=9, b=2: products are 8'h0F then 8'h12, 6 cycles apart. A `start` pulse raised mid-RUN is ignored.
- Force `timing`=6'b001100 during RUN: `phase_err`=1 one cycle later, `busy`=0, no `done`, `product` holds its previous value, and later `start` pulses are ignored until reset.
- Assert `reset`=0 for one edge while in RUN at T2: all outputs return to their reset values and no `done` occurs. After release, a=6, b=7 started at T0 gives `product`=8'h2A.
